// File: rtl/onehot_dispatch_pkg.sv
// Shared helpers for the one-hot dispatch/mux pair: select legality check and
// error counter sizing.
package onehot_dispatch_pkg;

  localparam int unsigned ERR_COUNT_WIDTH = 8;
  localparam int unsigned MAX_SEL_WIDTH   = 64;

  // Callers zero-extend narrower selects to MAX_SEL_WIDTH.
  function automatic logic onehot_valid(input logic [MAX_SEL_WIDTH-1:0] sel);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < MAX_SEL_WIDTH; i++) begin
      ones += int'(sel[i]);
    end
    return ones == 1;
  endfunction

endpackage

// File: rtl/onehot_dispatch_slot.sv
// One-entry output buffer for a single dispatch port: loads a word and holds it
// until the consumer drains it.
module onehot_dispatch_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             drain_i,
  output logic             full_o,
  output logic             free_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_d, full_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = load_data_i;
    end else if (full_q && drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  // Free when empty or being drained this cycle, so refill can overlap drain.
  assign free_o = !full_q || drain_i;
  assign data_o = data_q;

endmodule

// File: rtl/onehot_dispatch.sv
// Registered one-hot demultiplexer: routes each accepted word to one of
// PORT_QUANTITY one-entry port buffers; illegal selects are dropped and counted.
module onehot_dispatch
  import onehot_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned PORT_QUANTITY = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic [PORT_QUANTITY-1:0]         in_sel,
  output logic [PORT_QUANTITY-1:0]         out_valid,
  input  logic [PORT_QUANTITY-1:0]         out_ready,
  output logic [WIDTH*PORT_QUANTITY-1:0]   out_data,
  output logic                             sel_err,
  output logic [ERR_COUNT_WIDTH-1:0]       err_count
);

  logic                       sel_legal;
  logic                       drop;
  logic [PORT_QUANTITY-1:0]   port_free;
  logic [PORT_QUANTITY-1:0]   port_load;
  logic                       sel_err_d, sel_err_q;
  logic [ERR_COUNT_WIDTH-1:0] err_count_d, err_count_q;

  assign sel_legal = onehot_valid(MAX_SEL_WIDTH'(in_sel));

  // Illegal selects are always accepted so a bad word cannot wedge the input.
  assign in_ready  = sel_legal ? |(in_sel & port_free) : 1'b1;
  assign port_load = (in_valid && in_ready && sel_legal) ? in_sel : '0;
  assign drop      = in_valid && !sel_legal;

  for (genvar g = 0; g < PORT_QUANTITY; g++) begin : g_slot
    onehot_dispatch_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .load_i      (port_load[g]),
      .load_data_i (in_data),
      .drain_i     (out_ready[g]),
      .full_o      (out_valid[g]),
      .free_o      (port_free[g]),
      .data_o      (out_data[WIDTH*g +: WIDTH])
    );
  end

  always_comb begin
    sel_err_d   = drop;
    err_count_d = err_count_q;
    if (drop && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      sel_err_q   <= sel_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign sel_err   = sel_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_onehot_dispatch.sv
// Randomized self-checking bench for onehot_dispatch against a per-port
// buffer model plus directed scenarios.
module tb_onehot_dispatch;

  localparam int unsigned W = 32;
  localparam int unsigned P = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic [P-1:0]     in_sel = '0;
  logic [P-1:0]     out_valid;
  logic [P-1:0]     out_ready = '0;
  logic [W*P-1:0]   out_data;
  logic             sel_err;
  logic [7:0]       err_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: what each port currently holds, plus the error bookkeeping.
  bit          m_full [P];
  logic [W-1:0] m_data [P];
  int          m_err;
  bit          m_sel_err;

  onehot_dispatch #(
    .WIDTH         (W),
    .PORT_QUANTITY (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel_err   (sel_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < P; p++) begin
      m_full[p] = 1'b0;
      m_data[p] = '0;
    end
    m_err     = 0;
    m_sel_err = 1'b0;
  endtask

  // Drive one cycle of inputs, compare all outputs with the model, then advance.
  task automatic cycle(input logic v, input logic [P-1:0] s, input logic [W-1:0] d,
                       input logic [P-1:0] r);
    bit           legal;
    bit           exp_ready;
    logic [P-1:0] exp_ov;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    legal     = ($countones(s) == 1);
    exp_ready = 1'b1;
    for (int p = 0; p < P; p++) begin
      exp_ov[p] = m_full[p];
      if (legal && s[p]) exp_ready = !m_full[p] || r[p];
    end
    check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
    check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
    check_eq("sel_err", 64'(sel_err), 64'(m_sel_err));
    check_eq("err_count", 64'(err_count), 64'(m_err));
    for (int p = 0; p < P; p++) begin
      if (m_full[p]) check_eq($sformatf("out_data%0d", p), 64'(out_data[W*p +: W]),
                              64'(m_data[p]));
    end
    @(posedge clk);
    for (int p = 0; p < P; p++) begin
      if (m_full[p] && r[p]) m_full[p] = 1'b0;
      if (v && legal && exp_ready && s[p]) begin
        m_full[p] = 1'b1;
        m_data[p] = d;
      end
    end
    m_sel_err = v && !legal;
    if (m_sel_err && m_err < 255) m_err++;
  endtask

  function automatic logic [P-1:0] rand_sel(input int legal_pct);
    logic [P-1:0] s;
    if (int'($urandom_range(99)) < legal_pct) s = P'(1) << $urandom_range(P-1);
    else s = P'($urandom);
    return s;
  endfunction

  initial begin
    model_clear();
    // Reset held low with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_sel    = rand_sel(50);
      in_data   = $urandom;
      out_ready = P'($urandom);
      #1;
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_err_count", 64'(err_count), 64'(0));
      check_eq("rst_sel_err", 64'(sel_err), 64'(0));
      check_eq("rst_in_ready", 64'(in_ready), 64'(1));
      check_eq("rst_out_data", 64'(out_data), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b1, 4'b0100, 32'hDEADBEEF, 4'b0000);
    #1;
    check_eq("first_valid", 64'(out_valid), 64'(4'b0100));
    check_eq("first_data", 64'(out_data[W*2 +: W]), 64'(32'hDEADBEEF));
    cycle(1'b0, 4'b0000, '0, 4'b0100);

    // Stall isolation on port 1.
    cycle(1'b1, 4'b0010, 32'h1111, 4'b0000);
    cycle(1'b1, 4'b0010, 32'h2222, 4'b0000);
    #1;
    check_eq("stall_ready", 64'(in_ready), 64'(0));
    cycle(1'b1, 4'b1000, 32'h3333, 4'b0000);
    #1;
    check_eq("iso_valid", 64'(out_valid), 64'(4'b1010));
    check_eq("iso_data", 64'(out_data[W*3 +: W]), 64'(32'h3333));
    cycle(1'b0, 4'b0000, '0, 4'b1111);

    // Same-cycle drain/refill on port 0.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 4'b0001, W'(i), 4'b0001);
    cycle(1'b0, 4'b0000, '0, 4'b0001);
    cycle(1'b0, 4'b0000, '0, 4'b0001);

    // Two illegal selects.
    cycle(1'b1, 4'b0000, 32'hBAD0, 4'b0000);
    cycle(1'b1, 4'b0011, 32'hBAD1, 4'b0000);
    #1;
    check_eq("illegal_valid", 64'(out_valid), 64'(0));
    check_eq("illegal_count", 64'(err_count), 64'(2));
    cycle(1'b0, 4'b0000, '0, 4'b0000);
    cycle(1'b0, 4'b0000, '0, 4'b0000);

    // Saturation.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, ($urandom_range(1) != 0) ? 4'b0000 : 4'b1111, $urandom, 4'b0000);
    end
    #1;
    check_eq("sat_count", 64'(err_count), 64'(255));
    check_eq("sat_pulse", 64'(sel_err), 64'(1));

    // Async reset with three ports full.
    cycle(1'b1, 4'b0001, 32'hA0, 4'b0000);
    cycle(1'b1, 4'b0010, 32'hA1, 4'b0000);
    cycle(1'b1, 4'b1000, 32'hA2, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_clear", 64'(out_valid), 64'(0));
    check_eq("async_count", 64'(err_count), 64'(0));
    model_clear();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    cycle(1'b0, 4'b0000, '0, 4'b0000);
    cycle(1'b1, 4'b0100, 32'hC0FFEE, 4'b0000);
    #1;
    check_eq("post_rst_valid", 64'(out_valid), 64'(4'b0100));
    check_eq("post_rst_data", 64'(out_data[W*2 +: W]), 64'(32'hC0FFEE));

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(3) != 0), rand_sel(85), $urandom, P'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
